// File: rtl/gate_share_arbiter.sv
// Round-robin arbiter that time-shares one delayed 3-input gate among three requesters.
// It registers the winner's operands, waits SETTLE_CYCLES, captures the gate output and pulses done.
module gate_share_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [2:0] op2,
    output logic [2:0] gnt,
    output logic [2:0] gate_in,
    input  logic       gate_out,
    output logic       result,
    output logic [2:0] done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       rr_ptr_reg, rr_ptr_next;
    logic [2:0]       gnt_reg, gnt_next;
    logic [2:0]       gate_in_reg, gate_in_next;
    logic [2:0]       done_reg, done_next;
    logic             result_reg, result_next;

    logic [2:0]       op_sel [3];
    logic [1:0]       cand1, cand2, cand3, win;
    logic [2:0]       win_onehot;
    logic             grant_go, capture;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_settle
        $error("gate_share_arbiter: SETTLE_CYCLES=%0d out of range for CNT_W=%0d",
               SETTLE_CYCLES, CNT_W);
    end

    assign op_sel[0] = op0;
    assign op_sel[1] = op1;
    assign op_sel[2] = op2;

    // Search order starts just after the last winner and wraps modulo 3.
    assign cand1 = (rr_ptr_reg == 2'd2) ? 2'd0 : rr_ptr_reg + 2'd1;
    assign cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    assign cand3 = rr_ptr_reg;
    assign win   = req[cand1] ? cand1 : (req[cand2] ? cand2 : cand3);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_onehot
            assign win_onehot[gi] = (win == 2'(gi));
        end
    endgenerate

    assign grant_go = (state_reg == IDLE) && (req != 3'b000);
    assign capture  = (state_reg == SETTLE) && (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rr_ptr_reg  <= 2'd2;
            gnt_reg     <= 3'b000;
            gate_in_reg <= 3'b000;
            done_reg    <= 3'b000;
            result_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rr_ptr_reg  <= rr_ptr_next;
            gnt_reg     <= gnt_next;
            gate_in_reg <= gate_in_next;
            done_reg    <= done_next;
            result_reg  <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (grant_go) begin
                    state_next  = SETTLE;
                    cnt_next    = CNT_W'(SETTLE_CYCLES);
                    rr_ptr_next = win;
                end
            end
            SETTLE: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (capture) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs; done is a pulse so it defaults low.
    always_comb begin
        gnt_next     = gnt_reg;
        gate_in_next = gate_in_reg;
        done_next    = 3'b000;
        result_next  = result_reg;
        case (state_reg)
            IDLE: begin
                if (grant_go) begin
                    gnt_next     = win_onehot;
                    gate_in_next = op_sel[win];
                end else begin
                    gnt_next     = 3'b000;
                    gate_in_next = 3'b000;
                end
            end
            SETTLE: begin
                if (capture) begin
                    result_next  = gate_out;
                    done_next    = gnt_reg;
                    gnt_next     = 3'b000;
                    gate_in_next = 3'b000;
                end
            end
            default: begin
                gnt_next     = 3'b000;
                gate_in_next = 3'b000;
            end
        endcase
    end

    assign gnt     = gnt_reg;
    assign gate_in = gate_in_reg;
    assign done    = done_reg;
    assign result  = result_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Bench for gate_share_arbiter: a transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_gate_share_arbiter;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] op0 = 3'b000, op1 = 3'b000, op2 = 3'b000;
    logic [2:0] gnt, gate_in, done;
    logic       gate_out, result, busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Shared delayed AND cell
    assign #1 gate_out = &gate_in;

    gate_share_arbiter #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .op0      (op0),
        .op1      (op1),
        .op2      (op2),
        .gnt      (gnt),
        .gate_in  (gate_in),
        .gate_out (gate_out),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    // Model: one operation in flight, tracked by edges elapsed since its grant.
    bit         m_active = 1'b0;
    int         m_age = 0;
    int         m_win = 0;
    int         m_rr = 2;
    logic [2:0] m_ops = 3'b000;
    logic       m_result = 1'b0;

    initial begin
        int  c;
        bit  found;
        forever begin
            @(posedge clk);
            cycle++;
            if (!rst_n) begin
                m_active = 1'b0;
                m_rr     = 2;
                m_result = 1'b0;
            end else if (m_active) begin
                m_age++;
                if (m_age == S)     m_result = &m_ops;
                if (m_age == S + 1) m_active = 1'b0;
            end else if (req != 3'b000) begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    c = (m_rr + k) % 3;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_win = c;
                    end
                end
                case (m_win)
                    0:       m_ops = op0;
                    1:       m_ops = op1;
                    default: m_ops = op2;
                endcase
                m_rr     = m_win;
                m_active = 1'b1;
                m_age    = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [2:0] oh, e_gnt, e_done;
        @(posedge clk);
        forever begin
            @(negedge clk);
            oh     = 3'b001 << m_win;
            e_gnt  = (m_active && m_age < S)  ? oh : 3'b000;
            e_done = (m_active && m_age == S) ? oh : 3'b000;
            chk3("model_gnt", gnt, e_gnt);
            chk3("model_done", done, e_done);
            chk1("model_busy", busy, m_active);
            chk1("model_result", result, m_result);
            if (!(m_active && m_age == S))
                chk3("model_gate_in", gate_in, (m_active && m_age < S) ? m_ops : 3'b000);
        end
    end

    // Transaction log: grants and completions
    logic [2:0] gq[$];
    int         gcyc[$];
    int         done_cnt[3] = '{0, 0, 0};
    initial begin
        logic [2:0] prev_gnt;
        prev_gnt = 3'b000;
        forever begin
            @(posedge clk);
            #2;
            if (gnt !== 3'b000 && prev_gnt === 3'b000) begin
                gq.push_back(gnt);
                gcyc.push_back(cycle);
                $display("cycle %0d grant %b gate_in %b", cycle, gnt, gate_in);
            end
            for (int k = 0; k < 3; k++) begin
                if (done[k] === 1'b1) begin
                    done_cnt[k]++;
                    $display("cycle %0d done requester %0d result %b", cycle, k, result);
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 20);
        chk1(name, busy, 1'b0);
    endtask

    initial begin
        int d_before, n;

        // Reset held for two edges with all requests asserted
        rst_n = 1'b0; req = 3'b111; op0 = 3'b011;
        tick(); tick();
        chk3("rst_gnt", gnt, 3'b000);
        chk3("rst_done", done, 3'b000);
        chk3("rst_gate_in", gate_in, 3'b000);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_result", result, 1'b0);
        rst_n = 1'b1;
        tick();
        chk3("first_grant", gnt, 3'b001);
        req = 3'b000;
        wait_idle("idle_after_first");

        // Single op with all-ones operands; operand change mid-settle ignored
        op1 = 3'b111; req = 3'b010;
        tick(); chk3("single_gnt_c1", gnt, 3'b010);
        op1 = 3'b000;
        tick(); chk3("single_gnt_c2", gnt, 3'b010);
        tick(); chk3("single_done", done, 3'b010);
        chk3("single_gnt_off", gnt, 3'b000);
        chk1("single_result", result, 1'b1);
        req = 3'b000;
        tick(); chk3("single_done_pulse", done, 3'b000);
        wait_idle("idle_after_single");

        // Zero case
        op2 = 3'b101; req = 3'b100;
        tick(); chk3("zero_gate_in", gate_in, 3'b101);
        tick(); tick();
        chk3("zero_done", done, 3'b100);
        chk1("zero_result", result, 1'b0);
        req = 3'b000;
        wait_idle("idle_after_zero");

        // Fairness under continuous requests
        gq.delete(); gcyc.delete();
        op0 = 3'b111; op1 = 3'b110; op2 = 3'b111; req = 3'b111;
        n = 0;
        while (gq.size() < 4 && n < 40) begin
            tick();
            n++;
        end
        req = 3'b000;
        chki("fair_grant_count", gq.size(), 4);
        if (gq.size() >= 4) begin
            chk3("fair_g0", gq[0], 3'b001);
            chk3("fair_g1", gq[1], 3'b010);
            chk3("fair_g2", gq[2], 3'b100);
            chk3("fair_g3", gq[3], 3'b001);
            for (int i = 0; i < 3; i++)
                chki("fair_spacing", gcyc[i+1] - gcyc[i], S + 2);
        end
        wait_idle("idle_after_fair");

        // Reset during settle aborts the op without a done pulse
        req = 3'b111;
        tick(); chk3("midrst_gnt", gnt, 3'b010);
        d_before = done_cnt[1];
        rst_n = 1'b0;
        tick();
        chk3("midrst_gnt_clr", gnt, 3'b000);
        chk1("midrst_busy", busy, 1'b0);
        chk3("midrst_done", done, 3'b000);
        rst_n = 1'b1;
        tick(); chk3("midrst_regrant", gnt, 3'b001);
        chki("midrst_no_done", done_cnt[1], d_before);
        req = 3'b000;
        wait_idle("idle_after_midrst");

        // Abandoned request still completes exactly once
        gq.delete(); gcyc.delete();
        d_before = done_cnt[2];
        req = 3'b100;
        tick(); chk3("abandon_gnt", gnt, 3'b100);
        req = 3'b000;
        repeat (8) tick();
        chki("abandon_done_once", done_cnt[2] - d_before, 1);
        chki("abandon_one_grant", gq.size(), 1);
        chk1("abandon_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
